adc_sampler: RTL and testbench
==============================

# adc_sampler

Front-end for the board's 8-bit parallel ADC. The block generates the ADC conversion clock and output enable, captures raw conversion words, and discards the samples still in the ADC pipeline after start-up. It averages 2^AVG_LOG2 captures and presents a held result on `sample`. `sample` drives the 8-bit PIO input port read by the Nios; `sample_valid` feeds a separate PIO bit, whose edge capture signals a new result.

## Interface
Parameters:
- CLK_DIV, 4: adc_clk period in clk cycles; even, ≥2.
- PIPE_DELAY, 3: ADC conversion latency in adc_clk periods; these captures are discarded after each start.
- AVG_LOG2, 2: log2 of the number of captures averaged per result; range 0..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request, synchronous to clk.
- adc_data  in  8  ADC output bus, stable during the low phase of adc_clk.
- adc_clk  out  1  ADC conversion clock (flop output).
- adc_oe_n  out  1  ADC output enable, active low.
- sample  out  8  averaged result, held between updates.
- sample_valid  out  1  one-cycle pulse when `sample` updates.
- clip  out  1  set when any capture in the last window was 8'h00 or 8'hFF; updates together with `sample`.

## Operation
- States:
  - IDLE: adc_clk=0, adc_oe_n=1, div_cnt=0.
  - FLUSH: counts PIPE_DELAY captures and discards them.
  - RUN: accumulates captures.
- Transitions:
  - IDLE→FLUSH on the edge where enable is sampled 1.
  - FLUSH→RUN on the edge of the PIPE_DELAY-th capture.
  - PIPE_DELAY=0 means IDLE→RUN directly.
  - Any state→IDLE on the edge where enable is sampled 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps, in FLUSH and RUN only.
  - adc_clk flop is high while div_cnt < CLK_DIV/2 and low otherwise; the flop is computed from next-state values, so its output matches the div_cnt value for that cycle.
  - adc_oe_n=0 in FLUSH and RUN.
- Capture strobe: a capture occurs on any edge where the current div_cnt == CLK_DIV-1 and state ≠ IDLE, i.e. at the end of the adc_clk low phase. adc_data is sampled directly on that edge.
- Accumulation (RUN):
  - acc has width 8+AVG_LOG2, so it cannot overflow.
  - avg_cnt counts 0..2^AVG_LOG2-1.
  - Each capture adds adc_data to acc and ORs (adc_data==8'h00 || adc_data==8'hFF) into clip_acc.
- Result: on the capture where avg_cnt == 2^AVG_LOG2-1:
  - sample ← (acc+adc_data) >> AVG_LOG2, truncated (no rounding).
  - clip ← clip_acc OR current flag.
  - sample_valid ← 1 for exactly one cycle.
  - acc, avg_cnt and clip_acc clear.
- AVG_LOG2=0: every RUN capture produces a result equal to the raw value.
- Reset values:
  - Outputs: adc_clk=0, adc_oe_n=1, sample=0, sample_valid=0, clip=0.
  - Internal: state=IDLE; acc, avg_cnt, div_cnt and clip_acc all 0.

## Timing
- Enable sampled 1 at edge E0:
  - adc_clk is high from E0.
  - Captures occur at E0+m·CLK_DIV, m≥1.
  - The first result is produced at m = PIPE_DELAY + 2^AVG_LOG2. With defaults that is edge E0+28; sample_valid is high in the cycle following E0+28.
- Steady state: one result every CLK_DIV·2^AVG_LOG2 cycles.
- Latency: capture edge to sample/sample_valid is 1 cycle (registered).
- Enable falling mid-window: the partial acc is discarded and no pulse is produced; sample and clip hold. adc_clk is forced low on the next cycle, even mid-high-phase.
- Enable sampled 0 on a capture edge: the IDLE transition wins, and neither the capture nor the result is taken.
- Re-enable: always restarts with FLUSH and div_cnt=0.
- Asynchronous reset mid-run: all outputs and internal state return to the reset values immediately.

## Structure
- Package `adc_pkg`:
  - State enum (IDLE, FLUSH, RUN).
  - Function returning the acc width (8+AVG_LOG2).
  - Clip code constants 8'h00 and 8'hFF.
- Sub-module `adc_clk_gen`: div_cnt, adc_clk flop, capture strobe. Inputs are run/enable; the divider resets to 0 whenever run is low.
- Top level: state machine, flush counter, accumulator, output registers.

## Test plan
- Reset while running → adc_clk=0, adc_oe_n=1, sample=0, clip=0 immediately; no sample_valid.
- Defaults, adc_data held at 8'h40, enable held 1 → first sample_valid in the cycle after E0+28 with sample=8'h40; further pulses every 16 cycles; adc_clk is 2 high / 2 low.
- AVG_LOG2=2, captures 10,11,12,14 → sample=11 (47>>2, truncated); clip=0.
- One capture of 8'hFF within a window of 8'h80 values → clip=1 on that result; the next all-8'h80 window → clip=0.
- Enable dropped after 2 RUN captures → no pulse, sample holds its previous value, adc_clk low next cycle; re-enable → the first result again arrives 28 cycles later.
- AVG_LOG2=0, PIPE_DELAY=0, CLK_DIV=2 → one pulse every 2 cycles, sample equal to the raw capture; enable low on a capture edge → no update.

Source files
------------

// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the ADC front-end: FSM states, clip codes and
// accumulator sizing.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } adc_state_t;

    localparam logic [7:0] CLIP_LO = 8'h00;
    localparam logic [7:0] CLIP_HI = 8'hFF;

    // 2^avg_log2 eight-bit captures summed without overflow
    function automatic int unsigned acc_width(input int unsigned avg_log2);
        return 8 + avg_log2;
    endfunction

endpackage

// File: rtl/adc_sampler_clk_gen.sv
// ADC conversion clock divider: div_cnt, registered adc_clk and the capture
// strobe at the end of each adc_clk low phase.
module adc_clk_gen
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic enable,
    output logic adc_clk,
    output logic capture
);

    localparam int unsigned   DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF     = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_next;
    logic          adc_clk_next;

    // enable is the next-cycle run flag, so adc_clk follows the new div_cnt
    // and drops immediately when the block is switched off
    always_comb begin
        div_cnt_next = '0;
        if (run && enable) begin
            div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
        adc_clk_next = enable && (div_cnt_next < HALF);
        capture      = run && enable && (div_cnt == DIV_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else begin
            div_cnt <= div_cnt_next;
            adc_clk <= adc_clk_next;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// 8-bit parallel ADC front-end: flushes the converter pipeline after start,
// averages 2^AVG_LOG2 captures and presents a held result for the PIO port.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned PIPE_DELAY = 3,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] adc_data,
    output logic       adc_clk,
    output logic       adc_oe_n,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       clip
);

    localparam int unsigned   ACC_W      = acc_width(AVG_LOG2);
    localparam int unsigned   AW         = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [AW-1:0] AVG_LAST   = AW'((1 << AVG_LOG2) - 1);
    localparam int unsigned   FW         = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'((PIPE_DELAY > 0) ? PIPE_DELAY - 1 : 0);

    adc_state_t       state;
    adc_state_t       state_next;
    logic [FW-1:0]    flush_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [AW-1:0]    avg_cnt;
    logic             clip_acc;
    logic             run;
    logic             capture;
    logic             flag;
    logic             take;
    logic             last;

    assign run = (state != IDLE);

    adc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .enable  (enable),
        .adc_clk (adc_clk),
        .capture (capture)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = (PIPE_DELAY == 0) ? RUN : FLUSH;
            FLUSH:   if (capture && flush_cnt == FLUSH_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;

        flag = (adc_data == CLIP_LO) || (adc_data == CLIP_HI);
        sum  = acc + ACC_W'(adc_data);
        take = capture && (state == RUN);
        last = take && (avg_cnt == AVG_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt <= '0;
        end else if (state != FLUSH || !enable) begin
            flush_cnt <= '0;
        end else if (capture) begin
            flush_cnt <= flush_cnt + FW'(1);
        end
    end

    // a window in progress is dropped whenever the block leaves RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            avg_cnt  <= '0;
            clip_acc <= 1'b0;
        end else if (!enable || state != RUN || last) begin
            acc      <= '0;
            avg_cnt  <= '0;
            clip_acc <= 1'b0;
        end else if (take) begin
            acc      <= sum;
            avg_cnt  <= avg_cnt + AW'(1);
            clip_acc <= clip_acc | flag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_oe_n     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
        end else begin
            adc_oe_n     <= (state_next == IDLE);
            sample_valid <= last;
            if (last) begin
                sample <= sum[ACC_W-1:AVG_LOG2];
                clip   <= clip_acc | flag;
            end
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: default and fast (CLK_DIV=2, no flush, no averaging)
// instances checked every cycle against a time-since-enable reference model.
module tb_adc_sampler;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       ck0, oe0, v0, c0, ck1, oe1, v1, c1;
    logic [7:0] s0, s1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_sampler u_dflt (
        .clk(clk), .reset_n(reset_n), .enable(en0), .adc_data(d0),
        .adc_clk(ck0), .adc_oe_n(oe0), .sample(s0), .sample_valid(v0), .clip(c0)
    );

    adc_sampler #(.CLK_DIV(2), .PIPE_DELAY(0), .AVG_LOG2(0)) u_fast (
        .clk(clk), .reset_n(reset_n), .enable(en1), .adc_data(d1),
        .adc_clk(ck1), .adc_oe_n(oe1), .sample(s1), .sample_valid(v1), .clip(c1)
    );

    // Reference: t = edges since enable was sampled 1; capture m = t/CLK_DIV
    int cd [2] = '{4, 2};
    int pd [2] = '{3, 0};
    int al [2] = '{2, 0};
    int t [2];
    int wsum [2];
    bit wclip [2];
    int m_smp [2];
    bit m_val [2], m_clip [2], m_ck [2], m_oe [2];
    bit me;
    int md, mm;

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                t[i] = -1; wsum[i] = 0; wclip[i] = 0;
                m_smp[i] = 0; m_val[i] = 0; m_clip[i] = 0; m_ck[i] = 0; m_oe[i] = 1;
            end else begin
                me = (i == 0) ? en0 : en1;
                md = (i == 0) ? int'(d0) : int'(d1);
                m_val[i] = 0;
                if (!me) begin
                    t[i] = -1; wsum[i] = 0; wclip[i] = 0; m_ck[i] = 0; m_oe[i] = 1;
                end else begin
                    t[i] = (t[i] < 0) ? 0 : t[i] + 1;
                    if (t[i] > 0 && t[i] % cd[i] == 0) begin
                        mm = t[i] / cd[i];
                        if (mm > pd[i]) begin
                            wsum[i]  += md;
                            wclip[i] |= (md == 0 || md == 255);
                            if ((mm - pd[i]) % (1 << al[i]) == 0) begin
                                m_smp[i]  = wsum[i] >> al[i];
                                m_clip[i] = wclip[i];
                                m_val[i]  = 1;
                                wsum[i]   = 0;
                                wclip[i]  = 0;
                            end
                        end
                    end
                    m_ck[i] = (t[i] % cd[i]) < (cd[i] / 2);
                    m_oe[i] = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("dflt.adc_clk", ck0, m_ck[0]);
        check("dflt.adc_oe_n", oe0, m_oe[0]);
        check("dflt.sample_valid", v0, m_val[0]);
        check("dflt.sample", s0, m_smp[0]);
        check("dflt.clip", c0, m_clip[0]);
        check("fast.adc_clk", ck1, m_ck[1]);
        check("fast.adc_oe_n", oe1, m_oe[1]);
        check("fast.sample_valid", v1, m_val[1]);
        check("fast.sample", s1, m_smp[1]);
        check("fast.clip", c1, m_clip[1]);
    endtask

    function automatic logic [7:0] data_a(input int n);
        if (n == 16) return 8'd10;
        if (n == 20) return 8'd11;
        if (n == 24) return 8'd12;
        if (n == 28) return 8'd14;
        if (n < 29)  return 8'h00;
        if (n == 44) return 8'hFF;
        if (n <= 60) return 8'h80;
        return 8'h40;
    endfunction

    function automatic logic [7:0] rnd_data();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic next_en(input logic e);
        if (e) return ($urandom_range(0, 79) != 0);
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        check("rst.adc_clk", ck0, 0);
        check("rst.adc_oe_n", oe0, 1);
        check("rst.sample", s0, 0);
        check("rst.clip", c0, 0);
        check("rst.sample_valid", v0, 0);
        check("rst.fast_sample", s1, 0);
        #1 reset_n = 1'b1;
    endtask

    int         pt [$];
    int         ps [$];
    int         pc [$];
    int         exp_t [4] = '{28, 44, 60, 76};
    int         exp_s [4] = '{11, 159, 128, 64};
    int         exp_c [4] = '{0, 1, 0, 0};
    int         lat;
    logic [7:0] hold;

    initial begin
        reset_pulse();
        tick();

        // directed windows on the default instance; E0 is edge 0
        en0 = 1'b1;
        d0  = data_a(0);
        for (int n = 0; n < 86; n++) begin
            tick();
            if (v0) begin
                pt.push_back(n); ps.push_back(s0); pc.push_back(c0);
            end
            d0 = data_a(n + 1);
        end
        check("A.pulse_count", pt.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < pt.size()) begin
                check("A.pulse_edge", pt[k], exp_t[k]);
                check("A.pulse_sample", ps[k], exp_s[k]);
                check("A.pulse_clip", pc[k], exp_c[k]);
            end
        end

        // drop enable two captures into a window, mid adc_clk high phase
        en0 = 1'b0;
        tick();
        check("A.drop_adc_clk", ck0, 0);
        check("A.drop_sample_hold", s0, 8'h40);
        check("A.drop_no_pulse", v0, 0);
        for (int n = 0; n < 12; n++) begin
            tick();
            check("A.idle_no_pulse", v0, 0);
        end

        // re-enable: first result again 28 edges after the enable edge
        en0 = 1'b1;
        d0  = 8'h40;
        lat = 0;
        while (lat < 100) begin
            tick();
            if (v0) break;
            lat++;
        end
        check("A.reenable_latency", lat, 28);
        check("A.reenable_sample", s0, 8'h40);
        en0 = 1'b0;
        tick();

        // fast instance: result every capture, then disable on a capture edge
        en1 = 1'b1;
        for (int n = 0; n < 21; n++) begin
            d1 = rnd_data();
            tick();
        end
        lat = 0;
        while (t[1] % 2 == 0 && lat < 4) begin
            tick();
            lat++;
        end
        hold = s1;
        d1   = ~hold;
        en1  = 1'b0;
        tick();
        check("C.capture_edge_hold", s1, hold);
        check("C.capture_edge_no_pulse", v1, 0);

        // randomized enable/data on both instances with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) reset_pulse();
            en0 = next_en(en0);
            en1 = next_en(en1);
            d0  = rnd_data();
            d1  = rnd_data();
        end
        en0 = 1'b0;
        en1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
